// File: rtl/irq_multi_ctrl.sv
// Multi-channel interrupt controller: per-line synchronizer, edge select, sticky flag, enable,
// and a read-then-deselect lock that clears only the flags captured when the read began.
module irq_multi_ctrl #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [NCH-1:0] irq_in,
  input  logic [NCH-1:0] edge_sel,
  input  logic [NCH-1:0] irq_en,
  input  logic           readp,
  input  logic           deselect,
  output logic [NCH-1:0] flags,
  output logic           irq_n,
  output logic           isLocked
);

  // One-hot encoding leaves spare codes; those fall back to StIdle.
  typedef enum logic [1:0] {
    StIdle   = 2'b01,
    StLocked = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] flags_q, flags_d;
  logic [NCH-1:0] snap_q, snap_d;
  logic [NCH-1:0] sync_s;
  logic [NCH-1:0] rise, fall, new_sets;
  logic           lock_raw;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q  <= '0;
      flags_q <= '0;
      snap_q  <= '0;
      state_q <= StIdle;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q  <= sync_s;
      flags_q <= flags_d;
      snap_q  <= snap_d;
      state_q <= state_d;
    end
  end

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign rise     = sync_s & ~prev_q;
  assign fall     = ~sync_s & prev_q;
  // Edge history is taken on the synchronized line, so flipping edge_sel alone cannot fire.
  assign new_sets = (edge_sel & rise) | (~edge_sel & fall);

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    flags_d  = flags_q | new_sets;
    lock_raw = 1'b0;
    case (state_q)
      StIdle: begin
        lock_raw = readp;
        if (readp) begin
          state_d = StLocked;
          snap_d  = flags_q;
        end
      end
      StLocked: begin
        lock_raw = ~deselect;
        if (deselect) begin
          state_d = StIdle;
          // Sets arriving on the clearing edge win over the clear.
          flags_d = (flags_q & ~snap_q) | new_sets;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign flags    = flags_q;
  assign irq_n    = ~(nreset & (|(flags_q & irq_en)));
  assign isLocked = nreset & lock_raw;

endmodule

// File: tb/tb_irq_multi_ctrl.sv
// Directed bench for irq_multi_ctrl with a queue of expected observations checked in order.
module tb_irq_multi_ctrl;

  localparam int unsigned NCH = 2;

  logic           clk = 1'b0;
  logic           nreset;
  logic [NCH-1:0] irq_in;
  logic [NCH-1:0] edge_sel;
  logic [NCH-1:0] irq_en;
  logic           readp;
  logic           deselect;
  logic [NCH-1:0] flags;
  logic           irq_n;
  logic           isLocked;

  typedef struct {
    string    tag;
    int       kind;  // 0 flags, 1 irq_n, 2 isLocked
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  irq_multi_ctrl #(.NCH(NCH), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .irq_in   (irq_in),
    .edge_sel (edge_sel),
    .irq_en   (irq_en),
    .readp    (readp),
    .deselect (deselect),
    .flags    (flags),
    .irq_n    (irq_n),
    .isLocked (isLocked)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [7:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Pops every pending expectation and compares it with the DUT's current outputs.
  task automatic check_all();
    exp_t       e;
    logic [7:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       obs = {6'b0, flags};
        1:       obs = {7'b0, irq_n};
        default: obs = {7'b0, isLocked};
      endcase
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    nreset   = 1'b0;
    irq_in   = 2'b00;
    edge_sel = 2'b11;
    irq_en   = 2'b01;
    readp    = 1'b1;
    deselect = 1'b0;

    // Reset forces outputs regardless of readp.
    tick(2);
    push("rst_flags", 0, 8'h0);
    push("rst_irqn", 1, 8'h1);
    push("rst_lock", 2, 8'h0);
    check_all();
    nreset = 1'b1;
    push("rel_lock", 2, 8'h1);
    check_all();
    tick(1);
    readp    = 1'b0;
    deselect = 1'b1;
    tick(1);
    deselect = 1'b0;
    push("rel_flags", 0, 8'h0);
    check_all();

    // Rising edge on ch0: flag appears on the third edge after the change.
    irq_in = 2'b01;
    tick(2);
    push("rise_lat", 0, 8'h0);
    check_all();
    tick(1);
    push("rise_flag", 0, 8'h1);
    push("rise_irqn", 1, 8'h0);
    check_all();

    // One-cycle pulse on masked ch1.
    irq_in = 2'b11;
    tick(1);
    irq_in = 2'b01;
    tick(2);
    push("pulse_flags", 0, 8'h3);
    push("pulse_irqn", 1, 8'h0);
    check_all();

    // Clear both via handshake.
    readp = 1'b1;
    tick(1);
    readp    = 1'b0;
    deselect = 1'b1;
    tick(1);
    deselect = 1'b0;
    push("clr_flags", 0, 8'h0);
    push("clr_irqn", 1, 8'h1);
    check_all();

    // Falling edge on ch0.
    edge_sel = 2'b10;
    irq_in   = 2'b00;
    tick(3);
    push("fall_flag", 0, 8'h1);
    check_all();

    // Toggling edge_sel with steady lines must not set anything new.
    edge_sel = 2'b01;
    tick(3);
    edge_sel = 2'b00;
    tick(3);
    edge_sel = 2'b11;
    tick(3);
    push("sel_toggle", 0, 8'h1);
    check_all();

    // Read lock; ch1 edge during lock; deselect clears only snapshot bits.
    readp = 1'b1;
    push("rd_lock_mealy", 2, 8'h1);
    check_all();
    tick(1);
    readp = 1'b0;
    push("rd_lock_held", 2, 8'h1);
    check_all();
    irq_in = 2'b10;
    tick(3);
    push("lock_set_flags", 0, 8'h3);
    push("lock_set_lock", 2, 8'h1);
    check_all();
    deselect = 1'b1;
    push("desel_mealy", 2, 8'h0);
    check_all();
    tick(1);
    deselect = 1'b0;
    push("desel_flags", 0, 8'h2);
    push("desel_lock", 2, 8'h0);
    push("desel_irqn", 1, 8'h1);
    check_all();

    // Same-cycle set and clear on ch0.
    irq_in = 2'b11;
    tick(3);
    irq_in = 2'b10;
    tick(3);
    push("pre_same", 0, 8'h3);
    check_all();
    readp = 1'b1;
    tick(1);
    readp  = 1'b0;
    irq_in = 2'b11;
    tick(2);
    deselect = 1'b1;
    tick(1);
    deselect = 1'b0;
    push("same_cycle", 0, 8'h1);
    check_all();

    // readp and deselect together in IDLE, then held readp relocks after unlock.
    readp    = 1'b1;
    deselect = 1'b1;
    push("both_idle", 2, 8'h1);
    check_all();
    tick(1);
    push("both_locked", 2, 8'h0);
    check_all();
    tick(1);
    push("relock_flags", 0, 8'h0);
    push("relock_mealy", 2, 8'h1);
    check_all();
    tick(1);
    readp    = 1'b0;
    deselect = 1'b0;
    push("relock_held", 2, 8'h1);
    check_all();

    // Reset mid-lock with both flags set.
    edge_sel = 2'b00;
    irq_in   = 2'b00;
    tick(3);
    push("ml_flags", 0, 8'h3);
    push("ml_lock", 2, 8'h1);
    check_all();
    nreset = 1'b0;
    push("ml_rst_flags", 0, 8'h0);
    push("ml_rst_lock", 2, 8'h0);
    push("ml_rst_irqn", 1, 8'h1);
    check_all();
    nreset = 1'b1;
    tick(1);
    push("ml_idle_lock", 2, 8'h0);
    push("ml_idle_flags", 0, 8'h0);
    check_all();
    readp = 1'b1;
    push("ml_relock", 2, 8'h1);
    check_all();
    tick(1);
    readp = 1'b0;
    push("ml_relock_held", 2, 8'h1);
    check_all();
    deselect = 1'b1;
    tick(1);
    deselect = 1'b0;
    push("ml_unlock", 2, 8'h0);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_multi_ctrl.md
Name: irq_multi_ctrl

Overview:
Parametrised successor to the single-bit IRQ lock for the MC6820 PIA model. It handles NCH interrupt input lines, each with a synchronizer, a selectable active edge, a sticky flag and an enable. Flags are cleared by a read-then-deselect handshake. Only flags captured at the read are cleared; edges that arrive during the read cycle are never lost. It sits between the PIA control-line pins (CA1/CB1-style) and the register/bus interface.

Parameters:
NCH, 2, number of interrupt channels (1..8)
SYNC_STAGES, 2, flops in each input synchronizer (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
nreset  input  1  asynchronous active-low reset
irq_in  input  NCH  raw interrupt lines, asynchronous to clk
edge_sel  input  NCH  per-channel active edge: 1 = rising, 0 = falling
irq_en  input  NCH  per-channel enable onto irq_n
readp  input  1  status-register read strobe (level)
deselect  input  1  bus deselect, ends the read cycle
flags  output  NCH  sticky interrupt flags (registered)
irq_n  output  1  active-low combined interrupt request
isLocked  output  1  read-lock indicator

Behaviour:
- Clock and reset: one clock (clk); reset nreset is asynchronous and active-low.
- Reset values: all sync flops 0, all edge-history flops 0, flags = 0, snapshot = 0, lock state IDLE. While nreset = 0: irq_n = 1 and isLocked = 0, forced regardless of inputs.
- Synchronizer: SYNC_STAGES-deep chain per channel; s = last stage, p = s delayed by 1 clk.
- Edge detect: rise = s & ~p, fall = ~s & p; active = edge_sel ? rise : fall. Changing edge_sel alone never creates an edge.
- Because the chain resets to 0, a line held high through reset release produces one rising edge.
- Latency: an irq_in change before clk edge k sets the flag at edge k+SYNC_STAGES, i.e. 2 edges after it with the default.
- irq_n = ~|(flags & irq_en), combinational from registers. Masked flags still set and remain visible on flags.
- Lock FSM, 2 states:
  - IDLE: readp=1 -> LOCKED, snapshot <= flags (value before this edge's sets); else stay.
  - LOCKED: deselect=1 -> IDLE and flags <= (flags & ~snapshot) | new_sets; else stay.
  - readp is ignored in LOCKED; deselect is ignored in IDLE.
- isLocked (combinational, Mealy): (IDLE & readp) | (LOCKED & ~deselect).
- Simultaneous events:
  - A set and a clear on the same channel in the same cycle: set wins, flag stays 1.
  - readp and deselect both 1 in IDLE: enter LOCKED, isLocked = 1.
  - readp still 1 on the cycle after unlock: relock with a fresh snapshot.
- Reset mid-lock: immediate return to IDLE, flags cleared, no pending clear survives.
- Unused state encodings recover to IDLE.

Test Plan:
- Reset: drive nreset=0 with irq_in=0 and readp=1 -> flags=0, irq_n=1, isLocked=0; release reset -> isLocked=1 the same cycle.
- Rising edge, NCH=2, edge_sel=2'b11, irq_en=2'b01: irq_in[0] goes 0->1 -> flags[0]=1 exactly 2 clks later, irq_n=0. Pulse irq_in[1] -> flags=2'b11 and irq_n is unchanged by ch1 alone.
- Falling select: edge_sel[0]=0, irq_in[0] goes 1->0 -> flag set. Toggle edge_sel with irq_in steady -> no flag.
- Read-clear handshake: flags=2'b01, readp=1 for 1 clk -> isLocked=1 until deselect. An edge on ch1 during the lock sets flags[1]. On deselect -> flags=2'b10, isLocked=0.
- Same-cycle set and clear: ch0 edge lands on the deselect cycle with ch0 in the snapshot -> flags[0] stays 1.
- Reset mid-lock: LOCKED with flags=2'b11, pulse nreset low -> flags=0, isLocked=0, state IDLE; the next readp relocks normally.
